// File: rtl/seq_restoring_divider_pkg.sv
// Shared definitions for the sequential restoring divider: default width,
// FSM state encoding and the step-counter width helper.
package seq_restoring_divider_pkg;

   localparam int DIV_N = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_e;

   // One extra bit so the counter can represent N itself without wrapping.
   function automatic int step_cnt_width(input int n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/seq_restoring_divider_if.sv
// Start/busy/done request-and-result bundle of the divider; the requester
// uses the master modport and the divider the slave modport.
interface seq_restoring_divider_if
   import seq_restoring_divider_pkg::*;
#(
   parameter int N = DIV_N
);

   logic           start;
   logic [2*N-1:0] dividend;
   logic [N-1:0]   divisor;
   logic           busy;
   logic           done;
   logic [N-1:0]   quotient;
   logic [N-1:0]   remainder;
   logic           overflow;
   logic           div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, overflow, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, overflow, div_by_zero
   );

endinterface

// File: rtl/adder_subtractor.sv
// Ripple-carry adder/subtractor; with sign=1 it computes a - b and cout=1
// means no borrow occurred (a >= b as unsigned values).
module adder_subtractor #(
   parameter int W = 17
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         sign,
   output logic [W-1:0] sum,
   output logic         cout
);

   logic [W-1:0] b_eff;
   logic [W:0]   carry;

   // Subtraction is a + ~b + 1: invert b and feed sign in as the carry.
   always_comb begin
      b_eff    = b ^ {W{sign}};
      carry    = '0;
      carry[0] = sign;
      sum      = '0;
      for (int i = 0; i < W; i++) begin
         sum[i]     = a[i] ^ b_eff[i] ^ carry[i];
         carry[i+1] = (a[i] & b_eff[i]) | (carry[i] & (a[i] ^ b_eff[i]));
      end
      cout = carry[W];
   end

endmodule

// File: rtl/divider_step.sv
// One combinational restoring-division step: shift the next dividend bit
// into the partial remainder and subtract the divisor if it fits.
module divider_step
   import seq_restoring_divider_pkg::*;
#(
   parameter int N = DIV_N
) (
   input  logic [N:0]   rem_in,
   input  logic [N-1:0] divisor,
   input  logic         bit_in,
   output logic [N:0]   rem_out,
   output logic         q_bit
);

   logic [N:0] shifted;
   logic [N:0] diff;
   logic       no_borrow;
   logic       unused_rem_msb;

   // The partial remainder stays below the divisor, so its top bit is always
   // zero on entry and is shifted out.
   assign shifted        = {rem_in[N-1:0], bit_in};
   assign unused_rem_msb = rem_in[N];

   adder_subtractor #(
      .W (N + 1)
   ) u_sub (
      .a    (shifted),
      .b    ({1'b0, divisor}),
      .sign (1'b1),
      .sum  (diff),
      .cout (no_borrow)
   );

   assign q_bit   = no_borrow;
   assign rem_out = no_borrow ? diff : shifted;

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one quotient
// bit per clock, with an up-front overflow / divide-by-zero short cut.
module seq_restoring_divider
   import seq_restoring_divider_pkg::*;
#(
   parameter int N = DIV_N
) (
   input logic                    clk,
   input logic                    rst,
   seq_restoring_divider_if.slave bus
);

   localparam int             CW        = step_cnt_width(N);
   localparam logic [CW-1:0]  LAST_STEP = CW'(N - 1);

   div_state_e    state;
   div_state_e    state_next;

   logic [CW-1:0] step_cnt;
   logic [N:0]    part_rem;
   logic [N-1:0]  low_q;
   logic [N-1:0]  div_reg;

   logic [N-1:0]  quotient_r;
   logic [N-1:0]  remainder_r;
   logic          overflow_r;
   logic          dz_r;

   logic [N:0]    step_rem;
   logic          step_bit;
   logic [N-1:0]  shifted_q;
   logic          ovf_cmp;
   logic [N:0]    cmp_diff_unused;
   logic          accept;
   logic          last_step;

   // The quotient fits in N bits only if the upper dividend half is below the
   // divisor; a zero divisor always fails this compare.
   adder_subtractor #(
      .W (N + 1)
   ) u_cmp (
      .a    ({1'b0, bus.dividend[2*N-1:N]}),
      .b    ({1'b0, bus.divisor}),
      .sign (1'b1),
      .sum  (cmp_diff_unused),
      .cout (ovf_cmp)
   );

   divider_step #(
      .N (N)
   ) u_step (
      .rem_in  (part_rem),
      .divisor (div_reg),
      .bit_in  (low_q[N-1]),
      .rem_out (step_rem),
      .q_bit   (step_bit)
   );

   assign accept    = (state == IDLE) && bus.start;
   assign last_step = (state == RUN) && (step_cnt == LAST_STEP);
   assign shifted_q = {low_q[N-2:0], step_bit};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (bus.start) begin
               state_next = ovf_cmp ? DONE : RUN;
            end
         end
         RUN: begin
            if (step_cnt == LAST_STEP) begin
               state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Results are cleared on acceptance and otherwise held, so they stay valid
   // after the done pulse until the next request is taken.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         step_cnt    <= '0;
         part_rem    <= '0;
         low_q       <= '0;
         div_reg     <= '0;
         quotient_r  <= '0;
         remainder_r <= '0;
         overflow_r  <= 1'b0;
         dz_r        <= 1'b0;
      end else if (accept) begin
         div_reg     <= bus.divisor;
         part_rem    <= {1'b0, bus.dividend[2*N-1:N]};
         low_q       <= bus.dividend[N-1:0];
         step_cnt    <= '0;
         quotient_r  <= ovf_cmp ? '1 : '0;
         remainder_r <= '0;
         overflow_r  <= ovf_cmp;
         dz_r        <= (bus.divisor == '0);
      end else if (state == RUN) begin
         part_rem <= step_rem;
         low_q    <= shifted_q;
         step_cnt <= step_cnt + CW'(1);
         if (last_step) begin
            quotient_r  <= shifted_q;
            remainder_r <= step_rem[N-1:0];
         end
      end
   end

   assign bus.busy        = (state != IDLE);
   assign bus.done        = (state == DONE);
   assign bus.quotient    = quotient_r;
   assign bus.remainder   = remainder_r;
   assign bus.overflow    = overflow_r;
   assign bus.div_by_zero = dz_r;

endmodule

// File: doc/seq_restoring_divider.md
Name: seq_restoring_divider

Overview:
- Sequential restoring divider: the inverse of the 16-bit Karatsuba multiplier.
- Divides a 2N-bit dividend by an N-bit divisor and returns an N-bit quotient and an N-bit remainder.
- Produces one quotient bit per clock using the existing adder_subtractor ripple datapath.
- Start/busy/done handshake, so it drops into the datapath beside the multiplier; a multiplier product fed back with one factor returns the other factor.

Parameters:
N, 16, divisor/quotient/remainder width; dividend is 2N bits.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request pulse; sampled only in IDLE
dividend  input  2N  numerator; sampled on the accepting edge only
divisor  input  N  denominator; sampled on the accepting edge only
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse; results valid
quotient  output  N  result quotient
remainder  output  N  result remainder
overflow  output  1  quotient does not fit in N bits (includes divide-by-zero)
div_by_zero  output  1  divisor was 0

Behaviour:
Reset:
- rst high asynchronously forces state IDLE.
- All registers and all outputs go to 0.
- Reset mid-RUN aborts the operation with no done pulse.

States: IDLE, RUN, DONE.

IDLE, start=1 at edge k:
- Capture divisor into D and dividend into the shift register A.
- Compute ovf = (dividend[2N-1:N] >= divisor), using an (N+1)-bit adder_subtractor compare.
- Set dz = (divisor == 0).
- If ovf: go to DONE.
  - quotient = all ones, remainder = 0, overflow = 1, div_by_zero = dz.
  - done is high in the cycle after edge k (latency 1).
- Else: go to RUN.
  - Partial remainder R (N+1 bits) = {0, dividend[2N-1:N]}.
  - Low register Q = dividend[N-1:0]; step counter = 0.

RUN, each edge (one restoring step):
- S = {R[N-1:0], Q[N-1]}, N+1 bits.
- T = S - {0, D} via adder_subtractor (N+1 bits, sign=1).
- If cout=1 (non-negative): R = T and the new bit is 1; otherwise R = S and the new bit is 0.
- Q = {Q[N-2:0], new bit}.
- Counter increments. After the N-th step (edge k+N), latch quotient = Q and remainder = R[N-1:0], then go to DONE.
- done is high in the cycle after edge k+N, i.e. N+1 edges after acceptance.

DONE:
- done = 1 for exactly one cycle; the next edge returns to IDLE.

Results:
- quotient, remainder, overflow and div_by_zero hold their values from DONE until the next accepted start.
- On accepting a new start they clear to 0.

start handling:
- start while busy (RUN or DONE) is ignored: not queued, and does not corrupt the operation.
- start may be asserted on the same edge the block returns to IDLE from DONE; that edge is not accepted. The next edge with start=1 in IDLE is accepted.

Invariants (no overflow):
- Dividend = quotient*divisor + remainder.
- remainder < divisor.
- R never exceeds N significant bits after a step.

Width rules:
- All subtraction uses adder_subtractor with an explicit carry-out as the borrow indicator (cout=1 means no borrow).
- The counter is $clog2(N)+1 bits wide.
- No behavioural '/' or '%' operators.

Decomposition:
- Shared include file:
  - State encoding localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - Default width localparam DIV_N=16.
- Sub-module: divider_step, combinational.
  - Takes R, D and the incoming bit; returns new R and the quotient bit.
  - Internally one (N+1)-bit adder_subtractor.
- The top level holds the FSM, counter, A/Q/R/D registers and the overflow compare.

Test Plan:
1. N=16, dividend=32'd1000, divisor=16'd7, one-cycle start → done exactly 17 cycles after the accepting edge; quotient=142, remainder=6, overflow=0.
2. dividend=32'hFFFE0001, divisor=16'hFFFF → quotient=16'hFFFF, remainder=0, overflow=0; then dividend=32'h0000FFFF, divisor=16'h0100 → quotient=16'h00FF, remainder=16'h00FF.
3. dividend=32'h00010000, divisor=16'h0001 → done 1 cycle after acceptance; overflow=1, div_by_zero=0, quotient=16'hFFFF, remainder=0. Repeat with divisor=0 → overflow=1, div_by_zero=1.
4. Hold start high throughout a 1000/7 run with dividend changed to 32'd50 mid-run → a single done with result 142/6. The next accepted start (2 edges after done) computes 50/7 → quotient=7, remainder=1.
5. Assert rst at step 8 of a run → outputs all 0 immediately (asynchronous), no done; after release, 32'd81/16'd9 → quotient=9, remainder=0.
6. Round trip: 1000 random nonzero X,Y pairs; Z from karatsuba_16(X,Y); divide Z by Y → quotient=X, remainder=0, overflow=0 (Y=1 with X=16'hFFFF included).
